// File: rtl/alu_result_stage_pkg.sv
// Purpose: shared ALU definitions - default widths, packed result entry, opcode encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// The issue side reuses the opcode constants; the result stage uses the widths
// and the entry layout {tag, result, carry, zero, overflow}.
package alu_result_stage_pkg;

  localparam int ALU_WIDTH = 128;
  localparam int ALU_TAG_W = 4;

  // ALU opcodes, shared with the issue logic.
  localparam logic [3:0] ALU_OP_ADD = 4'h0;
  localparam logic [3:0] ALU_OP_SUB = 4'h1;
  localparam logic [3:0] ALU_OP_AND = 4'h2;
  localparam logic [3:0] ALU_OP_OR  = 4'h3;
  localparam logic [3:0] ALU_OP_XOR = 4'h4;
  localparam logic [3:0] ALU_OP_SHL = 4'h5;
  localparam logic [3:0] ALU_OP_SHR = 4'h6;
  localparam logic [3:0] ALU_OP_CMP = 4'h7;

  // Captured result entry at the default widths.
  typedef struct packed {
    logic [ALU_TAG_W-1:0] tag;
    logic [ALU_WIDTH-1:0] result;
    logic                 carry;
    logic                 zero;
    logic                 overflow;
  } alu_entry_t;

endpackage

// File: rtl/alu_result_fifo.sv
// Purpose: generic DEPTH x W synchronous FIFO with occupancy count, full and empty.
// Latency: a push is visible at rdata/!empty on the next cycle (no bypass).
// Backpressure: push is ignored while full, pop is ignored while empty.
//
// Ports: clk, rst (async, active-high); push/wdata write side; pop/rdata read
// side (rdata is the read-pointer entry); count/full/empty occupancy status.
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module alu_result_fifo #(
  parameter  int DEPTH = 2,
  parameter  int W     = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      // Simultaneous push and pop leave the occupancy unchanged.
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (!do_push && do_pop) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// Purpose: capture ALU results+flags+tag into a FIFO for writeback; sticky flags, zero check, retire count.
// Latency: 1 cycle from push to out_valid when empty; status updates visible the cycle after the event.
// Backpressure: in_ready = not full (registered state only); a full FIFO refuses a push even during a pop.
//
// Ports: in_* ALU side (valid/ready, tag, result, carry/zero/overflow);
// out_* writeback side (valid/ready, head entry); sticky_clr clears
// sticky_carry/sticky_overflow; zero_err flags an inconsistent in_zero
// (reset-only clear); retired_count counts pops modulo 2^CNT_W.
module alu_result_stage
  import alu_result_stage_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int TAG_W = ALU_TAG_W,
  parameter int DEPTH = 2,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_carry,
  input  logic             in_zero,
  input  logic             in_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_overflow,
  input  logic             sticky_clr,
  output logic             sticky_carry,
  output logic             sticky_overflow,
  output logic             zero_err,
  output logic [CNT_W-1:0] retired_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Same layout as the package entry, sized by this instance's parameters.
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;
    logic             overflow;
  } entry_t;

  entry_t        wr_entry;
  entry_t        head;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          zero_bad;

  assign wr_entry = '{tag: in_tag, result: in_result, carry: in_carry,
                      zero: in_zero, overflow: in_overflow};

  alu_result_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wr_entry),
    .pop   (pop),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Both handshakes derive from registered occupancy only; no out_ready -> in_ready path.
  assign in_ready  = (fifo_count != FULL_CNT);
  assign out_valid = !fifo_empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    if (!rst) begin
      assert (fifo_full == !in_ready);
    end
  end

  assign out_tag      = head.tag;
  assign out_result   = head.result;
  assign out_carry    = head.carry;
  assign out_zero     = head.zero;
  assign out_overflow = head.overflow;

  // ALU zero flag must agree with the result it accompanies.
  assign zero_bad = (in_zero != (in_result == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_carry    <= 1'b0;
      sticky_overflow <= 1'b0;
      zero_err        <= 1'b0;
      retired_count   <= '0;
    end else begin
      // A flag retiring in the same cycle as sticky_clr wins over the clear.
      sticky_carry    <= (sticky_carry    && !sticky_clr) || (pop && out_carry);
      sticky_overflow <= (sticky_overflow && !sticky_clr) || (pop && out_overflow);
      if (push && zero_bad) begin
        zero_err <= 1'b1;
      end
      if (pop) begin
        retired_count <= retired_count + 1'b1;
      end
    end
  end

endmodule
